// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard control unit.
package hazard_pkg;
    typedef enum logic {RUN, MC_WAIT} hc_state_t;
    localparam int REG_ZERO = 0;
    function automatic int fwd_sel_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// fwd_select: picks the youngest forwarding source whose destination matches
// the operand register; x0 never forwards.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int REG_W   = 5,
    parameter int SEL_W   = fwd_sel_w(NUM_FWD)
) (
    input  logic [REG_W-1:0]         i_rs,
    input  logic [NUM_FWD-1:0]       i_we,
    input  logic [NUM_FWD*REG_W-1:0] i_rd,
    output logic [SEL_W-1:0]         o_sel
);
    // Scan oldest to youngest so the lowest matching index wins.
    always_comb begin
        o_sel = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--)
            if (i_we[k] && i_rd[k*REG_W +: REG_W] == i_rs && i_rs != REG_W'(REG_ZERO))
                o_sel = SEL_W'(k + 1);
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and forwarding control for the in-order pipeline,
// including the multi-cycle wait FSM with watchdog timeout.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_FWD    = 2,
    parameter int REG_W      = 5,
    parameter int MC_TIMEOUT = 64,
    parameter int FWD_SEL_W  = fwd_sel_w(NUM_FWD)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REG_W-1:0]         rs1_d,
    input  logic [REG_W-1:0]         rs2_d,
    input  logic [REG_W-1:0]         rs1_e,
    input  logic [REG_W-1:0]         rs2_e,
    input  logic                     load_e,
    input  logic [REG_W-1:0]         rd_e,
    input  logic [NUM_FWD-1:0]       fwd_we,
    input  logic [NUM_FWD*REG_W-1:0] fwd_rd,
    input  logic                     mc_start_e,
    input  logic                     mc_done,
    input  logic                     jump_d,
    input  logic                     branch_d,
    input  logic                     mispredict_e,
    output logic                     stall_f,
    output logic                     stall_d,
    output logic                     stall_e,
    output logic                     flush_d,
    output logic                     flush_e,
    output logic [FWD_SEL_W-1:0]     fwd_a_e,
    output logic [FWD_SEL_W-1:0]     fwd_b_e,
    output logic                     mc_busy,
    output logic                     mc_timeout
);
    localparam int CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

    hc_state_t        r_state;
    hc_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_wait, w_to, w_hold, w_lu;
    logic [FWD_SEL_W-1:0] w_fwd_a, w_fwd_b;

    fwd_select #(.NUM_FWD(NUM_FWD), .REG_W(REG_W), .SEL_W(FWD_SEL_W)) u_fwd_a (
        .i_rs(rs1_e), .i_we(fwd_we), .i_rd(fwd_rd), .o_sel(w_fwd_a)
    );
    fwd_select #(.NUM_FWD(NUM_FWD), .REG_W(REG_W), .SEL_W(FWD_SEL_W)) u_fwd_b (
        .i_rs(rs2_e), .i_we(fwd_we), .i_rd(fwd_rd), .o_sel(w_fwd_b)
    );

    // Counter is held at zero in RUN, so it is already clear on entry to MC_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (r_state == RUN) ? '0 : r_cnt + 1'b1;
            r_timeout <= r_timeout | w_to;
        end
    end

    always_comb begin
        w_wait = r_state == MC_WAIT;
        w_to   = w_wait && !mc_done && r_cnt == CNT_W'(MC_TIMEOUT - 1);
        w_hold = w_wait && !mc_done && !w_to;
        w_lu   = load_e && rd_e != REG_W'(REG_ZERO) && (rs1_d == rd_e || rs2_d == rd_e);
        w_next = w_wait ? ((mc_done || w_to) ? RUN : MC_WAIT)
                        : ((mc_start_e && !mc_done) ? MC_WAIT : RUN);
    end

    // Outputs are forced low while reset is asserted, including the forwarding selects.
    assign stall_f    = rst_n && (w_hold || (!w_wait && !mispredict_e && w_lu));
    assign stall_d    = stall_f;
    assign stall_e    = rst_n && w_hold;
    assign flush_e    = rst_n && (w_to || (!w_wait && (mispredict_e || w_lu)));
    assign flush_d    = rst_n && !w_wait && (mispredict_e || (!w_lu && (jump_d || branch_d)));
    assign mc_busy    = rst_n && w_hold;
    assign mc_timeout = r_timeout;
    assign fwd_a_e    = rst_n ? w_fwd_a : '0;
    assign fwd_b_e    = rst_n ? w_fwd_b : '0;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (MC_TIMEOUT = 12).
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic       load_e, mc_start_e, mc_done, jump_d, branch_d, mispredict_e;
    logic [1:0] fwd_we;
    logic [9:0] fwd_rd;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, mc_busy, mc_timeout;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic [10:0] obs;
    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [10:0] exp;
    } exp_t;
    exp_t sb[$];

    hazard_ctrl #(.NUM_FWD(2), .REG_W(5), .MC_TIMEOUT(12)) dut (
        .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .load_e(load_e), .rd_e(rd_e), .fwd_we(fwd_we), .fwd_rd(fwd_rd),
        .mc_start_e(mc_start_e), .mc_done(mc_done), .jump_d(jump_d), .branch_d(branch_d),
        .mispredict_e(mispredict_e), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .mc_busy(mc_busy), .mc_timeout(mc_timeout)
    );

    always #5 clk = ~clk;

    assign obs = {stall_f, stall_d, stall_e, flush_d, flush_e, mc_busy, mc_timeout, fwd_a_e, fwd_b_e};

    always @(posedge clk)
        assert (!(mc_start_e && mispredict_e)) else begin
            failures++;
            $error("FAIL illegal_stimulus mc_start_e and mispredict_e both high");
        end

    function automatic logic [10:0] ov(input logic sf, sd, se, fd, fe, bz, to,
                                       input logic [1:0] fa, fb);
        return {sf, sd, se, fd, fe, bz, to, fa, fb};
    endfunction

    task automatic clr();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e} = '0;
        {load_e, mc_start_e, mc_done, jump_d, branch_d, mispredict_e} = '0;
        fwd_we = '0;
        fwd_rd = '0;
    endtask

    task automatic check();
        exp_t x;
        #2;
        x = sb.pop_front();
        checks++;
        assert (obs === x.exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.exp);
        end
    endtask

    task automatic step(input string tag, input logic [10:0] e);
        sb.push_back('{tag, e});
        check();
    endtask

    initial begin
        clr();
        // Reset state: hazard and forwarding triggers present but outputs forced low.
        @(negedge clk);
        fwd_we = 2'b11; fwd_rd = {5'd7, 5'd7}; rs1_e = 5'd7; load_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
        step("reset_state", '0);
        @(negedge clk); clr(); rst_n = 1'b1;
        step("idle_after_reset", '0);
        // Forwarding
        @(negedge clk); fwd_we = 2'b11; fwd_rd = {5'd7, 5'd7}; rs1_e = 5'd7; rs2_e = 5'd7;
        step("fwd_both_prio", ov(0,0,0,0,0,0,0,2'd1,2'd1));
        @(negedge clk); rs1_e = 5'd0; fwd_we = 2'b10;
        step("fwd_x0_and_src1", ov(0,0,0,0,0,0,0,2'd0,2'd2));
        @(negedge clk); fwd_we = 2'b11; fwd_rd = {5'd3, 5'd9}; rs1_e = 5'd3; rs2_e = 5'd9;
        step("fwd_distinct", ov(0,0,0,0,0,0,0,2'd2,2'd1));
        @(negedge clk); fwd_we = 2'b00;
        step("fwd_disabled", '0);
        // Load-use
        @(negedge clk); clr(); load_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5;
        step("loaduse_hit", ov(1,1,0,0,1,0,0,0,0));
        @(negedge clk); clr(); rs2_d = 5'd5;
        step("loaduse_cleared", '0);
        @(negedge clk); load_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd6;
        step("loaduse_nodep", '0);
        @(negedge clk); rd_e = 5'd0; rs1_d = 5'd0;
        step("loaduse_x0", '0);
        // Control hazards and priority
        @(negedge clk); clr(); load_e = 1'b1; rd_e = 5'd4; rs1_d = 5'd4; jump_d = 1'b1;
        step("jump_held_by_loaduse", ov(1,1,0,0,1,0,0,0,0));
        @(negedge clk); clr(); branch_d = 1'b1;
        step("branch_flush_d", ov(0,0,0,1,0,0,0,0,0));
        @(negedge clk); load_e = 1'b1; rd_e = 5'd4; rs1_d = 5'd4; jump_d = 1'b1; mispredict_e = 1'b1;
        step("mispredict_prio", ov(0,0,0,1,1,0,0,0,0));
        // Multi-cycle op completing after 10 wait cycles
        @(negedge clk); clr(); mc_start_e = 1'b1;
        step("mc_issue", '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); clr(); jump_d = (i == 4);
            step($sformatf("mc_wait_%0d", i), ov(1,1,1,0,0,1,0,0,0));
        end
        @(negedge clk); clr(); mc_done = 1'b1;
        step("mc_done_release", '0);
        @(negedge clk); clr(); branch_d = 1'b1;
        step("mc_back_in_run", ov(0,0,0,1,0,0,0,0,0));
        // Single-cycle completion
        @(negedge clk); clr(); mc_start_e = 1'b1; mc_done = 1'b1;
        step("mc_single_cycle", '0);
        @(negedge clk); clr();
        step("mc_single_no_wait", '0);
        // Watchdog timeout: 12 cycles in MC_WAIT, last one aborts
        @(negedge clk); mc_start_e = 1'b1;
        step("to_issue", '0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); clr();
            step($sformatf("to_wait_%0d", i), ov(1,1,1,0,0,1,0,0,0));
        end
        @(negedge clk);
        step("to_abort", ov(0,0,0,0,1,0,0,0,0));
        @(negedge clk);
        step("to_sticky_run", ov(0,0,0,0,0,0,1,0,0));
        @(negedge clk); load_e = 1'b1; rd_e = 5'd8; rs1_d = 5'd8;
        step("to_sticky_loaduse", ov(1,1,0,0,1,0,1,0,0));
        // Asynchronous reset in the third MC_WAIT cycle
        @(negedge clk); clr(); mc_start_e = 1'b1;
        step("rst_issue", ov(0,0,0,0,0,0,1,0,0));
        @(negedge clk); clr();
        step("rst_wait_0", ov(1,1,1,0,0,1,1,0,0));
        @(negedge clk);
        step("rst_wait_1", ov(1,1,1,0,0,1,1,0,0));
        @(negedge clk);
        step("rst_wait_2", ov(1,1,1,0,0,1,1,0,0));
        rst_n = 1'b0;
        step("rst_async", '0);
        @(negedge clk); rst_n = 1'b1;
        step("rst_release_run", '0);
        @(negedge clk); jump_d = 1'b1;
        step("rst_run_jump", ov(0,0,0,1,0,0,0,0,0));
        @(negedge clk); clr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
